// File: rtl/instr_fetch_reg_pkg.sv
// Shared CPU definitions: instruction field positions, opcode constants,
// the NOP encoding and the fetch FSM state encoding.
package instr_fetch_reg_pkg;

    // All-zero word is the MIPS NOP (sll $0,$0,0).
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Instruction field bit positions.
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int RS_MSB     = 25;
    localparam int RS_LSB     = 21;
    localparam int RT_MSB     = 20;
    localparam int RT_LSB     = 16;
    localparam int RD_MSB     = 15;
    localparam int RD_LSB     = 11;
    localparam int SHAMT_MSB  = 10;
    localparam int SHAMT_LSB  = 6;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;
    localparam int JT_MSB     = 25;
    localparam int JT_LSB     = 0;

    // Opcode constants used by the decode stage.
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // Fetch register FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_reg_field_decode.sv
// Splits an instruction word into its MIPS fields. Purely combinational so
// the decode stage can reuse it without adding latency.
module field_decode
    import instr_fetch_reg_pkg::*;
(
    input  logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [15:0] imm16,
    output logic [25:0] jtarget
);

    assign opcode  = instr[OPCODE_MSB:OPCODE_LSB];
    assign rs      = instr[RS_MSB:RS_LSB];
    assign rt      = instr[RT_MSB:RT_LSB];
    assign rd      = instr[RD_MSB:RD_LSB];
    assign shamt   = instr[SHAMT_MSB:SHAMT_LSB];
    assign funct   = instr[FUNCT_MSB:FUNCT_LSB];
    assign imm16   = instr[IMM_MSB:IMM_LSB];
    assign jtarget = instr[JT_MSB:JT_LSB];

endmodule

// File: rtl/instr_fetch_reg.sv
// Instruction register with memory handshake: captures the fetched word on
// request, waits for slow memory with a timeout, and keeps a free-running
// memory data register alongside.
module instr_fetch_reg
    import instr_fetch_reg_pkg::*;
#(
    parameter logic [31:0] RESET_INSTR = NOP_INSTR,
    parameter logic [7:0]  TIMEOUT     = 8'd16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ir_write,
    input  logic        flush,
    input  logic [31:0] mem_rdata,
    input  logic        mem_valid,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [15:0] imm16,
    output logic [25:0] jtarget,
    output logic [31:0] mdr,
    output logic        ir_valid,
    output logic        busy,
    output logic        fetch_err
);

    // Last WAIT count before giving up; TIMEOUT wait cycles in total.
    localparam logic [7:0] TIMEOUT_LAST = TIMEOUT - 8'd1;

    fetch_state_t state_q, state_d;
    logic [31:0]  instr_q, instr_d;
    logic         ir_valid_q, ir_valid_d;
    logic         fetch_err_q, fetch_err_d;
    logic [7:0]   wait_cnt_q, wait_cnt_d;
    logic [31:0]  mdr_q;

    // Next-state and next-register values; flush overrides every state.
    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        instr_d     = instr_q;
        ir_valid_d  = ir_valid_q;
        fetch_err_d = fetch_err_q;
        wait_cnt_d  = wait_cnt_q;

        if (flush) begin
            state_d    = ST_IDLE;
            instr_d    = RESET_INSTR;
            ir_valid_d = 1'b0;
            wait_cnt_d = 8'd0;
        end else begin
            case (state_q)
                ST_IDLE, ST_HOLD: begin
                    if (ir_write) begin
                        fetch_err_d = 1'b0;
                        if (mem_valid) begin
                            instr_d    = mem_rdata;
                            ir_valid_d = 1'b1;
                            state_d    = ST_HOLD;
                        end else begin
                            ir_valid_d = 1'b0;
                            wait_cnt_d = 8'd0;
                            state_d    = ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    // ir_write is deliberately ignored while waiting.
                    if (mem_valid) begin
                        instr_d    = mem_rdata;
                        ir_valid_d = 1'b1;
                        wait_cnt_d = 8'd0;
                        state_d    = ST_HOLD;
                    end else if (wait_cnt_q == TIMEOUT_LAST) begin
                        fetch_err_d = 1'b1;
                        wait_cnt_d  = 8'd0;
                        state_d     = ST_IDLE;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    ir_valid_d = 1'b0;
                    wait_cnt_d = 8'd0;
                end
            endcase
        end
    end

    // FSM and instruction-register state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            instr_q     <= RESET_INSTR;
            ir_valid_q  <= 1'b0;
            fetch_err_q <= 1'b0;
            wait_cnt_q  <= 8'd0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q     <= state_d;
            instr_q     <= instr_d;
            ir_valid_q  <= ir_valid_d;
            fetch_err_q <= fetch_err_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    // Memory data register: loads whenever memory presents data.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: mdr is a datapath register but still reset, since its value
        // is architecturally visible right after reset.
        if (!reset_n) begin
            mdr_q <= 32'd0;
        end else if (mem_valid) begin
            mdr_q <= mem_rdata;
        end
    end

    assign instr     = instr_q;
    assign mdr       = mdr_q;
    assign ir_valid  = ir_valid_q;
    assign fetch_err = fetch_err_q;
    assign busy      = (state_q == ST_WAIT);

    field_decode u_field_decode (
        .instr   (instr_q),
        .opcode  (opcode),
        .rs      (rs),
        .rt      (rt),
        .rd      (rd),
        .shamt   (shamt),
        .funct   (funct),
        .imm16   (imm16),
        .jtarget (jtarget)
    );

endmodule

// File: tb/tb_instr_fetch_reg.sv
// Scoreboard bench for instr_fetch_reg: the driver steps a transaction-level
// model and queues the expected outputs for each edge; the monitor compares
// them against the DUT one time unit after each rising edge.
module tb_instr_fetch_reg;

    localparam logic [31:0] RST_INSTR = 32'h0000_0000;
    localparam int          TMO       = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ir_write = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_valid = 1'b0;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm16;
    logic [25:0] jtarget;
    logic [31:0] mdr;
    logic        ir_valid;
    logic        busy;
    logic        fetch_err;

    instr_fetch_reg #(
        .RESET_INSTR (RST_INSTR),
        .TIMEOUT     (8'(TMO))
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ir_write  (ir_write),
        .flush     (flush),
        .mem_rdata (mem_rdata),
        .mem_valid (mem_valid),
        .instr     (instr),
        .opcode    (opcode),
        .rs        (rs),
        .rt        (rt),
        .rd        (rd),
        .shamt     (shamt),
        .funct     (funct),
        .imm16     (imm16),
        .jtarget   (jtarget),
        .mdr       (mdr),
        .ir_valid  (ir_valid),
        .busy      (busy),
        .fetch_err (fetch_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] mdr;
        logic        ir_valid;
        logic        busy;
        logic        fetch_err;
    } expect_t;

    expect_t exp_q[$];
    int checks = 0;
    int errors = 0;

    // Reference model: "pending" means a fetch is outstanding, "waited" is
    // the number of wait cycles that have already elapsed without data.
    logic [31:0] m_instr;
    logic [31:0] m_mdr;
    logic        m_ir_valid;
    logic        m_fetch_err;
    bit          m_pending;
    int          m_waited;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_instr     = RST_INSTR;
        m_mdr       = 32'd0;
        m_ir_valid  = 1'b0;
        m_fetch_err = 1'b0;
        m_pending   = 1'b0;
        m_waited    = 0;
    endfunction

    function automatic void model_step(input logic wr, input logic fl,
                                       input logic [31:0] data, input logic vld);
        if (vld) m_mdr = data;
        if (fl) begin
            m_instr    = RST_INSTR;
            m_ir_valid = 1'b0;
            m_pending  = 1'b0;
            m_waited   = 0;
        end else if (m_pending) begin
            if (vld) begin
                m_instr    = data;
                m_ir_valid = 1'b1;
                m_pending  = 1'b0;
            end else begin
                m_waited++;
                if (m_waited == TMO) begin
                    m_fetch_err = 1'b1;
                    m_pending   = 1'b0;
                end
            end
        end else if (wr) begin
            m_fetch_err = 1'b0;
            if (vld) begin
                m_instr    = data;
                m_ir_valid = 1'b1;
            end else begin
                m_pending  = 1'b1;
                m_waited   = 0;
                m_ir_valid = 1'b0;
            end
        end
    endfunction

    function automatic void push_expect();
        expect_t e;
        e.instr     = m_instr;
        e.mdr       = m_mdr;
        e.ir_valid  = m_ir_valid;
        e.busy      = m_pending;
        e.fetch_err = m_fetch_err;
        exp_q.push_back(e);
    endfunction

    // Drive one clock cycle of stimulus and queue what the next edge must produce.
    task automatic cycle(input logic wr, input logic fl, input logic [31:0] data, input logic vld);
        @(negedge clk);
        reset_n   = 1'b1;
        ir_write  = wr;
        flush     = fl;
        mem_rdata = data;
        mem_valid = vld;
        model_step(wr, fl, data, vld);
        push_expect();
    endtask

    // Assert reset mid-cycle, check its asynchronous effect, then queue the
    // reset state for the edge that follows; the next cycle() releases it.
    task automatic pulse_reset();
        @(negedge clk);
        ir_write  = 1'b0;
        flush     = 1'b0;
        mem_valid = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_instr", instr, RST_INSTR);
        check("async_rst_mdr", mdr, 32'd0);
        check("async_rst_ir_valid", 32'(ir_valid), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_fetch_err", 32'(fetch_err), 32'd0);
        model_reset();
        push_expect();
    endtask

    // Monitor: one expected snapshot per rising edge once stimulus starts.
    initial begin
        expect_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("instr", instr, e.instr);
                check("mdr", mdr, e.mdr);
                check("ir_valid", 32'(ir_valid), 32'(e.ir_valid));
                check("busy", 32'(busy), 32'(e.busy));
                check("fetch_err", 32'(fetch_err), 32'(e.fetch_err));
                check("opcode", 32'(opcode), 32'(e.instr[31:26]));
                check("rs", 32'(rs), 32'(e.instr[25:21]));
                check("rt", 32'(rt), 32'(e.instr[20:16]));
                check("rd", 32'(rd), 32'(e.instr[15:11]));
                check("shamt", 32'(shamt), 32'(e.instr[10:6]));
                check("funct", 32'(funct), 32'(e.instr[5:0]));
                check("imm16", 32'(imm16), 32'(e.instr[15:0]));
                check("jtarget", 32'(jtarget), 32'(e.instr[25:0]));
            end
        end
    end

    // Driver: directed scenarios followed by randomized traffic.
    initial begin
        int wait_budget;
        model_reset();
        #3;
        check("por_instr", instr, RST_INSTR);
        check("por_mdr", mdr, 32'd0);
        check("por_ir_valid", 32'(ir_valid), 32'd0);
        check("por_busy", 32'(busy), 32'd0);

        // Single-cycle capture of an addi word.
        cycle(1'b1, 1'b0, 32'h2008_FFFF, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);

        // Three cycles without data, then a lw word arrives.
        cycle(1'b1, 1'b0, 32'h1111_1111, 1'b0);
        cycle(1'b0, 1'b0, 32'h2222_2222, 1'b0);
        cycle(1'b0, 1'b0, 32'h3333_3333, 1'b0);
        cycle(1'b0, 1'b0, 32'h8C09_0004, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);

        // Timeout, with ir_write pulses in WAIT that must be ignored.
        cycle(1'b1, 1'b0, $urandom, 1'b0);
        for (int i = 0; i < TMO + 3; i++)
            cycle(1'($urandom_range(0, 1)), 1'b0, $urandom, 1'b0);
        // Flush together with ir_write must leave fetch_err set.
        cycle(1'b1, 1'b1, $urandom, 1'b0);
        // Next accepted ir_write clears fetch_err.
        cycle(1'b1, 1'b0, 32'hAAAA_5555, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);

        // Data on the last possible wait cycle wins over the timeout.
        cycle(1'b1, 1'b0, $urandom, 1'b0);
        for (int i = 0; i < TMO - 1; i++)
            cycle(1'b0, 1'b0, $urandom, 1'b0);
        cycle(1'b0, 1'b0, 32'h1234_5678, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);

        // Flush in WAIT alongside valid data: instr cleared, mdr still loads.
        cycle(1'b1, 1'b0, $urandom, 1'b0);
        cycle(1'b0, 1'b1, 32'hCAFE_F00D, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);

        // Reset mid-WAIT abandons the fetch; late data is not captured.
        cycle(1'b1, 1'b0, 32'h5A5A_5A5A, 1'b1);
        cycle(1'b1, 1'b0, $urandom, 1'b0);
        cycle(1'b0, 1'b0, $urandom, 1'b0);
        pulse_reset();
        cycle(1'b0, 1'b0, 32'h0BAD_0BAD, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);

        // mdr-only load while holding an instruction.
        cycle(1'b1, 1'b0, 32'h0000_4020, 1'b1);
        cycle(1'b0, 1'b0, 32'hDEAD_BEEF, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);

        // Random traffic, alternating phases of sparse and dense memory data.
        for (int n = 0; n < 3000; n++) begin
            int pct_valid;
            pct_valid = ((n / 400) % 2 == 1) ? 3 : 45;
            if ($urandom_range(0, 999) < 5) begin
                pulse_reset();
            end else begin
                cycle(1'($urandom_range(0, 99) < 30),
                      1'($urandom_range(0, 99) < 3),
                      $urandom,
                      1'($urandom_range(0, 99) < pct_valid));
            end
        end

        // Let the monitor consume everything queued, within a fixed budget.
        wait_budget = 10;
        while (exp_q.size() > 0 && wait_budget > 0) begin
            @(posedge clk);
            #2;
            wait_budget--;
        end
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_reg.md
INSTR_FETCH_REG -- requirements
Module: instr_fetch_reg

Interface
REQ-001 SHALL have parameter RESET_INSTR, default 32'h0000_0000, instruction value loaded on reset/flush (MIPS NOP).
REQ-002 SHALL have parameter TIMEOUT, default 8'd16, max cycles in WAIT before fetch error.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 ir_write  input  1  control-FSM request to capture the fetched instruction.
REQ-006 flush  input  1  discard held/pending instruction.
REQ-007 mem_rdata  input  32  memory read data.
REQ-008 mem_valid  input  1  mem_rdata valid this cycle.
REQ-009 instr  output  32  held instruction register.
REQ-010 opcode/rs/rt/rd/shamt/funct  output  6/5/5/5/5/6  fields of instr: [31:26]/[25:21]/[20:16]/[15:11]/[10:6]/[5:0].
REQ-011 imm16  output  16  instr[15:0], consumed by the sign-extension stage.
REQ-012 jtarget  output  26  instr[25:0].
REQ-013 mdr  output  32  memory data register.
REQ-014 ir_valid  output  1  instr holds a newly captured instruction.
REQ-015 busy  output  1  waiting for memory after ir_write.
REQ-016 fetch_err  output  1  sticky timeout flag.

Function
REQ-017 FSM states SHALL be IDLE, WAIT, HOLD.
REQ-018 IDLE or HOLD, ir_write=1, mem_valid=1: next edge instr<=mem_rdata, ir_valid<=1, state HOLD (1-cycle latency).
REQ-019 IDLE or HOLD, ir_write=1, mem_valid=0: state WAIT, ir_valid<=0, busy<=1, wait_cnt<=0, instr keeps its old value.
REQ-020 WAIT, mem_valid=1: instr<=mem_rdata, ir_valid<=1, busy<=0, state HOLD.
REQ-021 WAIT, mem_valid=0: wait_cnt increments; when wait_cnt==TIMEOUT-1, next edge fetch_err<=1, busy<=0, state IDLE, instr unchanged.
REQ-022 ir_write in WAIT SHALL be ignored (no restart, counter not cleared).
REQ-023 mem_valid and timeout on the same WAIT cycle: capture wins, fetch_err not set.
REQ-024 fetch_err SHALL clear only on reset or on the next accepted ir_write.
REQ-025 flush SHALL have top priority in any state: instr<=RESET_INSTR, ir_valid<=0, busy<=0, wait_cnt<=0, state IDLE; fetch_err unchanged.
REQ-026 mdr SHALL load mem_rdata on every edge with mem_valid=1, independent of FSM state and flush.
REQ-027 Field outputs (opcode..jtarget) SHALL be purely combinational slices of instr, with no extra latency.
REQ-028 ir_valid SHALL remain 1 in HOLD until flush or a new ir_write.
REQ-029 wait_cnt SHALL be 8 bits wide; TIMEOUT in range 1..255.

Reset
REQ-030 reset_n=0 SHALL immediately force: state IDLE, instr=RESET_INSTR, mdr=0, ir_valid=0, busy=0, fetch_err=0, wait_cnt=0.
REQ-031 Reset asserted mid-WAIT SHALL abandon the pending fetch; a mem_valid arriving after reset release with no new ir_write is not captured into instr.

Structure
REQ-032 Field bit positions, opcode constants, NOP value and FSM state encodings SHALL live in the shared CPU package.
REQ-033 A single sub-module, field_decode, SHALL split instr into the field outputs; it is reusable by the decode stage.

Verification
REQ-034 ir_write=1 and mem_valid=1 with mem_rdata=32'h2008_FFFF -> next cycle instr=32'h2008_FFFF, opcode=6'h08, rt=5'd8, imm16=16'hFFFF, ir_valid=1.
REQ-035 ir_write=1, mem_valid low for 3 cycles, then mem_rdata=32'h8C09_0004 valid -> busy=1 for 3 cycles, then instr=32'h8C09_0004, busy=0.
REQ-036 ir_write=1, mem_valid held low, TIMEOUT=16 -> fetch_err=1 after 16 cycles, state IDLE, instr unchanged; next accepted ir_write clears fetch_err.
REQ-037 flush asserted in WAIT together with mem_valid=1 -> instr=32'h0, ir_valid=0, and mdr still loads mem_rdata.
REQ-038 reset_n pulsed low mid-WAIT -> all outputs at reset values asynchronously; a later mem_valid with no ir_write leaves instr=32'h0.
REQ-039 mem_valid=1 with data 32'hDEAD_BEEF and ir_write=0 -> mdr=32'hDEAD_BEEF, instr and ir_valid unchanged.
